// File: rtl/pipeline_decode.sv
// Decode stage: IF/ID latch, field split, register scoreboard and registered ID/EX bundle.
// Fetch -> IF/ID -> ID/EX takes two cycles; decode_stall holds fetch on RAW hazard or execute stall.
module pipeline_decode #(
  parameter int         NUM_REGS   = 8,
  parameter int         REG_BITS   = 3,
  parameter logic [6:0] CMP_OPCODE = 7'b0000101
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [15:0]         fetch_pc,
  input  logic [15:0]         fetch_instr,
  input  logic                fetch_valid,
  input  logic                execute_stall,
  input  logic                execute_flush,
  input  logic                wb_valid,
  input  logic [REG_BITS-1:0] wb_rd,
  output logic                decode_stall,
  output logic                dec_valid,
  output logic [15:0]         dec_pc,
  output logic [6:0]          dec_opcode,
  output logic [REG_BITS-1:0] dec_rd,
  output logic [REG_BITS-1:0] dec_rs1,
  output logic [REG_BITS-1:0] dec_rs2,
  output logic [15:0]         dec_imm,
  output logic                dec_writes_rd,
  output logic                dec_is_cmp
);

  typedef struct packed {
    logic [15:0]         pc;
    logic [6:0]          opcode;
    logic [REG_BITS-1:0] rd;
    logic [REG_BITS-1:0] rs1;
    logic [REG_BITS-1:0] rs2;
    logic [15:0]         imm;
    logic                writes_rd;
    logic                is_cmp;
  } idex_t;

  logic                ifid_vld_q, ifid_vld_d;
  logic [15:0]         ifid_pc_q, ifid_pc_d;
  logic [15:0]         ifid_instr_q, ifid_instr_d;
  logic                idex_vld_q, idex_vld_d;
  idex_t               idex_q, idex_d, id_dec;
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic                rs1_hz, rs2_hz, hazard, handoff;

  always_comb begin
    id_dec.pc        = ifid_pc_q;
    id_dec.opcode    = ifid_instr_q[15:9];
    id_dec.rd        = ifid_instr_q[8:6];
    id_dec.rs1       = ifid_instr_q[5:3];
    id_dec.rs2       = ifid_instr_q[2:0];
    id_dec.imm       = {{10{ifid_instr_q[5]}}, ifid_instr_q[5:0]};
    id_dec.is_cmp    = (ifid_instr_q[15:9] == CMP_OPCODE);
    id_dec.writes_rd = (ifid_instr_q[15:9] != CMP_OPCODE) && !ifid_instr_q[15] &&
                       (ifid_instr_q[8:6] != '0);
  end

  // A source conflicts with a retired-but-pending write or with the writer sitting in ID/EX.
  assign rs1_hz = (id_dec.rs1 != '0) &&
                  (busy_q[id_dec.rs1] || (idex_vld_q && idex_q.writes_rd && idex_q.rd == id_dec.rs1));
  assign rs2_hz = (id_dec.rs2 != '0) &&
                  (busy_q[id_dec.rs2] || (idex_vld_q && idex_q.writes_rd && idex_q.rd == id_dec.rs2));
  assign hazard       = ifid_vld_q && (rs1_hz || rs2_hz);
  assign decode_stall = !execute_flush && ifid_vld_q && (execute_stall || hazard);
  assign handoff      = idex_vld_q && !execute_stall && !execute_flush;

  always_comb begin
    busy_d = busy_q;
    if (wb_valid && wb_rd != '0) busy_d[wb_rd] = 1'b0;
    if (handoff && idex_q.writes_rd) busy_d[idex_q.rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_comb begin
    ifid_vld_d   = ifid_vld_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_instr_d = ifid_instr_q;
    idex_vld_d   = idex_vld_q;
    idex_d       = idex_q;
    if (execute_flush) begin
      ifid_vld_d = 1'b0;
      idex_vld_d = 1'b0;
    end else if (!execute_stall) begin
      if (hazard) begin
        idex_vld_d = 1'b0;
      end else begin
        idex_vld_d   = ifid_vld_q;
        idex_d       = id_dec;
        ifid_vld_d   = fetch_valid;
        ifid_pc_d    = fetch_pc;
        ifid_instr_d = fetch_instr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ifid_vld_q   <= 1'b0;
      ifid_pc_q    <= '0;
      ifid_instr_q <= '0;
      idex_vld_q   <= 1'b0;
      idex_q       <= '0;
      busy_q       <= '0;
    end else begin
      ifid_vld_q   <= ifid_vld_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_instr_q <= ifid_instr_d;
      idex_vld_q   <= idex_vld_d;
      idex_q       <= idex_d;
      busy_q       <= busy_d;
    end
  end

  assign dec_valid     = idex_vld_q;
  assign dec_pc        = idex_q.pc;
  assign dec_opcode    = idex_q.opcode;
  assign dec_rd        = idex_q.rd;
  assign dec_rs1       = idex_q.rs1;
  assign dec_rs2       = idex_q.rs2;
  assign dec_imm       = idex_q.imm;
  assign dec_writes_rd = idex_q.writes_rd;
  assign dec_is_cmp    = idex_q.is_cmp;

endmodule

// File: tb/tb_pipeline_decode.sv
// Bench for pipeline_decode: directed scenarios plus a randomized run against a cycle-level reference model.
module tb_pipeline_decode;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] fetch_pc, fetch_instr;
  logic        fetch_valid, execute_stall, execute_flush, wb_valid;
  logic [2:0]  wb_rd;
  logic        decode_stall, dec_valid, dec_writes_rd, dec_is_cmp;
  logic [15:0] dec_pc, dec_imm;
  logic [6:0]  dec_opcode;
  logic [2:0]  dec_rd, dec_rs1, dec_rs2;

  int total, bad;

  localparam logic [6:0] ADD = 7'h01;
  localparam logic [6:0] CMP = 7'h05;

  pipeline_decode dut (
    .clk(clk), .reset(reset), .fetch_pc(fetch_pc), .fetch_instr(fetch_instr),
    .fetch_valid(fetch_valid), .execute_stall(execute_stall), .execute_flush(execute_flush),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .decode_stall(decode_stall), .dec_valid(dec_valid),
    .dec_pc(dec_pc), .dec_opcode(dec_opcode), .dec_rd(dec_rd), .dec_rs1(dec_rs1),
    .dec_rs2(dec_rs2), .dec_imm(dec_imm), .dec_writes_rd(dec_writes_rd), .dec_is_cmp(dec_is_cmp)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mk(input logic [6:0] op, input logic [2:0] rd,
                                     input logic [2:0] a, input logic [2:0] b);
    return {op, rd, a, b};
  endfunction

  task automatic idle();
    fetch_valid = 1'b0; fetch_pc = '0; fetch_instr = '0;
    execute_stall = 1'b0; execute_flush = 1'b0; wb_valid = 1'b0; wb_rd = '0;
  endtask

  task automatic fetch(input logic [15:0] pc, input logic [15:0] ins);
    fetch_valid = 1'b1; fetch_pc = pc; fetch_instr = ins;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; idle(); step(); step(); reset = 1'b0;
  endtask

  // Reference model: instruction words as plain integers, busy set as an array.
  bit m_if_v, m_ex_v;
  int m_if_pc, m_if_ins, m_ex_pc, m_ex_ins;
  bit m_busy [8];

  function automatic int f_op(input int ins);  return (ins / 512) % 128; endfunction
  function automatic int f_rd(input int ins);  return (ins / 64) % 8;    endfunction
  function automatic int f_rs1(input int ins); return (ins / 8) % 8;     endfunction
  function automatic int f_rs2(input int ins); return ins % 8;           endfunction
  function automatic int f_imm(input int ins);
    int i6 = ins % 64;
    return (i6 >= 32) ? i6 + 65536 - 64 : i6;
  endfunction
  function automatic bit f_writes(input int ins);
    return f_op(ins) != 5 && f_op(ins) < 64 && f_rd(ins) != 0;
  endfunction
  function automatic bit m_dep(input int r);
    return r != 0 && (m_busy[r] || (m_ex_v && f_writes(m_ex_ins) && f_rd(m_ex_ins) == r));
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    fetch(16'hABCD, mk(ADD, 3'd1, 3'd2, 3'd3));
    wb_valid = 1'b1; wb_rd = 3'd2;
    step(); step();
    @(negedge clk);
    total++; if (dec_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%0b exp=0", dec_valid); end
    total++; if (decode_stall !== 1'b0) begin bad++; $display("FAIL rst_stall got=%0b exp=0", decode_stall); end
    total++; if ({dec_pc, dec_opcode, dec_rd, dec_rs1, dec_rs2, dec_imm, dec_writes_rd, dec_is_cmp} !== '0) begin
      bad++; $display("FAIL rst_fields pc=%h op=%h imm=%h exp=0", dec_pc, dec_opcode, dec_imm);
    end
    reset = 1'b0; idle();
    fetch(16'h0005, mk(ADD, 3'd1, 3'd4, 3'd5)); step();
    idle(); step(); step();
    fetch(16'h0006, mk(ADD, 3'd0, 3'd1, 3'd0)); step();
    @(negedge clk);
    total++; if (decode_stall !== 1'b1) begin bad++; $display("FAIL rst_busy_pre got=%0b exp=1", decode_stall); end
    reset = 1'b1; step(); reset = 1'b0; idle();
    @(negedge clk);
    total++; if (dec_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_valid got=%0b exp=0", dec_valid); end
    total++; if (decode_stall !== 1'b0) begin bad++; $display("FAIL rst_mid_stall got=%0b exp=0", decode_stall); end
    fetch(16'h0006, mk(ADD, 3'd0, 3'd1, 3'd0)); step();
    idle();
    @(negedge clk);
    total++; if (decode_stall !== 1'b0) begin bad++; $display("FAIL rst_busy_cleared got=%0b exp=0", decode_stall); end
    step();
  endtask

  task automatic test_stream();
    do_reset();
    for (int c = 0; c < 6; c++) begin
      if (c < 3) fetch(16'(c), mk(ADD, 3'(c + 1), 3'd4, 3'd5)); else idle();
      @(negedge clk);
      total++; if (decode_stall !== 1'b0) begin bad++; $display("FAIL stream_stall c%0d got=%0b exp=0", c, decode_stall); end
      total++; if (dec_valid !== (c >= 2 && c <= 4)) begin bad++; $display("FAIL stream_valid c%0d got=%0b", c, dec_valid); end
      if (c >= 2 && c <= 4) begin
        total++; if (dec_pc !== 16'(c - 2) || dec_rd !== 3'(c - 1)) begin
          bad++; $display("FAIL stream_pc c%0d got pc=%0d rd=%0d exp pc=%0d rd=%0d", c, dec_pc, dec_rd, c - 2, c - 1);
        end
      end
      step();
    end
  endtask

  task automatic test_raw_hazard();
    int ev [9] = '{0, 0, 1, 0, 0, 0, 0, 1, 1};
    int ep [9] = '{0, 0, 10, 0, 0, 0, 0, 11, 12};
    int es [9] = '{0, 0, 1, 1, 1, 1, 0, 0, 0};
    do_reset();
    for (int c = 0; c < 9; c++) begin
      idle();
      if (c == 0) fetch(16'd10, mk(ADD, 3'd1, 3'd0, 3'd0));
      else if (c == 1) fetch(16'd11, mk(ADD, 3'd2, 3'd1, 3'd0));
      else if (c <= 6) fetch(16'd12, mk(ADD, 3'd3, 3'd4, 3'd5));
      if (c == 5) begin wb_valid = 1'b1; wb_rd = 3'd1; end
      @(negedge clk);
      total++; if (decode_stall !== es[c][0]) begin bad++; $display("FAIL raw_stall c%0d got=%0b exp=%0d", c, decode_stall, es[c]); end
      total++; if (dec_valid !== ev[c][0]) begin bad++; $display("FAIL raw_valid c%0d got=%0b exp=%0d", c, dec_valid, ev[c]); end
      if (ev[c] == 1) begin
        total++; if (dec_pc !== 16'(ep[c])) begin bad++; $display("FAIL raw_pc c%0d got=%0d exp=%0d", c, dec_pc, ep[c]); end
      end
      step();
    end
  endtask

  task automatic test_exec_stall();
    int ev [12] = '{0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
    int ep [12] = '{0, 0, 20, 21, 21, 21, 21, 22, 23, 24, 25, 0};
    int es [12] = '{0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0};
    int fp = 20;
    bit seen;
    do_reset();
    for (int c = 0; c < 12; c++) begin
      idle();
      if (fp <= 25) fetch(16'(fp), mk(ADD, 3'((fp - 20) % 3 + 1), 3'd4, 3'd5));
      execute_stall = (c >= 3 && c <= 5);
      @(negedge clk);
      seen = decode_stall;
      total++; if (decode_stall !== es[c][0]) begin bad++; $display("FAIL xstall_stall c%0d got=%0b exp=%0d", c, decode_stall, es[c]); end
      total++; if (dec_valid !== ev[c][0]) begin bad++; $display("FAIL xstall_valid c%0d got=%0b exp=%0d", c, dec_valid, ev[c]); end
      if (ev[c] == 1) begin
        total++; if (dec_pc !== 16'(ep[c]) || dec_rd !== 3'((ep[c] - 20) % 3 + 1)) begin
          bad++; $display("FAIL xstall_pc c%0d got pc=%0d rd=%0d exp pc=%0d", c, dec_pc, dec_rd, ep[c]);
        end
      end
      step();
      if (!seen && fp <= 25) fp++;
    end
  endtask

  task automatic test_flush();
    int ev [8] = '{0, 0, 1, 1, 0, 0, 1, 0};
    int ep [8] = '{0, 0, 30, 31, 0, 0, 40, 0};
    int es [8] = '{0, 0, 0, 0, 0, 0, 1, 1};
    do_reset();
    for (int c = 0; c < 8; c++) begin
      idle();
      case (c)
        0: fetch(16'd30, mk(ADD, 3'd3, 3'd4, 3'd5));
        1: fetch(16'd31, mk(ADD, 3'd1, 3'd4, 3'd5));
        2: fetch(16'd32, mk(ADD, 3'd2, 3'd4, 3'd5));
        3: begin fetch(16'd33, mk(ADD, 3'd1, 3'd4, 3'd5)); execute_flush = 1'b1; execute_stall = 1'b1; end
        4: fetch(16'd40, mk(ADD, 3'd0, 3'd1, 3'd0));
        5: fetch(16'd41, mk(ADD, 3'd0, 3'd3, 3'd0));
        default: ;
      endcase
      @(negedge clk);
      total++; if (decode_stall !== es[c][0]) begin bad++; $display("FAIL flush_stall c%0d got=%0b exp=%0d", c, decode_stall, es[c]); end
      total++; if (dec_valid !== ev[c][0]) begin bad++; $display("FAIL flush_valid c%0d got=%0b exp=%0d", c, dec_valid, ev[c]); end
      if (ev[c] == 1) begin
        total++; if (dec_pc !== 16'(ep[c])) begin bad++; $display("FAIL flush_pc c%0d got=%0d exp=%0d", c, dec_pc, ep[c]); end
      end
      step();
    end
  endtask

  task automatic test_imm();
    do_reset();
    fetch(16'h50, 16'hFFFF); step();
    fetch(16'h51, 16'h001F); step();
    fetch(16'h52, 16'h0220);
    @(negedge clk);
    total++; if (dec_valid !== 1'b1 || dec_imm !== 16'hFFFF || dec_opcode !== 7'h7F || dec_writes_rd !== 1'b0) begin
      bad++; $display("FAIL imm_neg got v=%0b imm=%h op=%h wr=%0b exp imm=ffff op=7f wr=0", dec_valid, dec_imm, dec_opcode, dec_writes_rd);
    end
    step(); idle();
    @(negedge clk);
    total++; if (dec_imm !== 16'h001F || dec_rs1 !== 3'd3 || dec_rs2 !== 3'd7) begin
      bad++; $display("FAIL imm_pos got imm=%h rs1=%0d rs2=%0d exp imm=001f rs1=3 rs2=7", dec_imm, dec_rs1, dec_rs2);
    end
    step();
    @(negedge clk);
    total++; if (dec_imm !== 16'hFFE0 || dec_opcode !== 7'h01 || dec_rs1 !== 3'd4) begin
      bad++; $display("FAIL imm_min got imm=%h op=%h rs1=%0d exp imm=ffe0 op=01 rs1=4", dec_imm, dec_opcode, dec_rs1);
    end
    step();
  endtask

  task automatic test_cmp();
    do_reset();
    for (int c = 0; c < 5; c++) begin
      idle();
      if (c == 0) fetch(16'd60, mk(CMP, 3'd2, 3'd4, 3'd5));
      else if (c == 1) fetch(16'd61, mk(ADD, 3'd0, 3'd2, 3'd2));
      else if (c == 2) fetch(16'd62, mk(ADD, 3'd0, 3'd2, 3'd0));
      @(negedge clk);
      total++; if (decode_stall !== 1'b0) begin bad++; $display("FAIL cmp_stall c%0d got=%0b exp=0", c, decode_stall); end
      if (c == 2) begin
        total++; if (dec_is_cmp !== 1'b1 || dec_writes_rd !== 1'b0 || dec_rd !== 3'd2) begin
          bad++; $display("FAIL cmp_flags got cmp=%0b wr=%0b rd=%0d exp cmp=1 wr=0 rd=2", dec_is_cmp, dec_writes_rd, dec_rd);
        end
      end
      if (c >= 3) begin
        total++; if (dec_valid !== 1'b1 || dec_pc !== 16'(58 + c) || dec_is_cmp !== 1'b0) begin
          bad++; $display("FAIL cmp_reader c%0d got v=%0b pc=%0d cmp=%0b exp v=1 pc=%0d cmp=0", c, dec_valid, dec_pc, dec_is_cmp, 58 + c);
        end
      end
      step();
    end
  endtask

  task automatic test_set_clear();
    do_reset();
    fetch(16'd70, mk(ADD, 3'd3, 3'd4, 3'd5)); step();
    idle(); step();
    fetch(16'd72, mk(ADD, 3'd0, 3'd3, 3'd0)); wb_valid = 1'b1; wb_rd = 3'd3; step();
    @(negedge clk);
    total++; if (decode_stall !== 1'b1) begin bad++; $display("FAIL setclr_win got=%0b exp=1", decode_stall); end
    step(); idle();
    @(negedge clk);
    total++; if (decode_stall !== 1'b0) begin bad++; $display("FAIL setclr_release got=%0b exp=0", decode_stall); end
    step();
    @(negedge clk);
    total++; if (dec_valid !== 1'b1 || dec_pc !== 16'd72) begin
      bad++; $display("FAIL setclr_issue got v=%0b pc=%0d exp v=1 pc=72", dec_valid, dec_pc);
    end
    step();
  endtask

  task automatic test_r0();
    do_reset();
    for (int c = 0; c < 5; c++) begin
      idle();
      if (c == 0) begin fetch(16'd80, mk(ADD, 3'd0, 3'd0, 3'd0)); wb_valid = 1'b1; end
      else if (c == 1) fetch(16'd81, mk(ADD, 3'd0, 3'd0, 3'd0));
      else if (c == 2) fetch(16'd82, mk(7'h02, 3'd0, 3'd0, 3'd0));
      @(negedge clk);
      total++; if (decode_stall !== 1'b0) begin bad++; $display("FAIL r0_stall c%0d got=%0b exp=0", c, decode_stall); end
      if (c >= 2) begin
        total++; if (dec_valid !== 1'b1 || dec_pc !== 16'(78 + c) || dec_writes_rd !== 1'b0) begin
          bad++; $display("FAIL r0_issue c%0d got v=%0b pc=%0d wr=%0b exp v=1 pc=%0d wr=0", c, dec_valid, dec_pc, dec_writes_rd, 78 + c);
        end
      end
      step();
    end
  endtask

  task automatic test_random();
    bit hz, exp_st, ho;
    logic [6:0] op;
    do_reset();
    m_if_v = 0; m_ex_v = 0; m_if_pc = 0; m_if_ins = 0; m_ex_pc = 0; m_ex_ins = 0;
    for (int i = 0; i < 8; i++) m_busy[i] = 0;
    for (int n = 0; n < 600; n++) begin
      reset = ($urandom_range(0, 99) == 0);
      fetch_valid = ($urandom_range(0, 3) != 0);
      fetch_pc = 16'($urandom);
      case ($urandom_range(0, 3))
        0: op = ADD;
        1: op = CMP;
        2: op = {1'b1, 6'($urandom)};
        default: op = 7'($urandom);
      endcase
      fetch_instr = {op, 3'($urandom), 3'($urandom), 3'($urandom)};
      execute_stall = ($urandom_range(0, 5) == 0);
      execute_flush = ($urandom_range(0, 11) == 0);
      wb_valid = ($urandom_range(0, 2) == 0);
      wb_rd = 3'($urandom);
      hz = m_if_v && (m_dep(f_rs1(m_if_ins)) || m_dep(f_rs2(m_if_ins)));
      exp_st = !execute_flush && m_if_v && (execute_stall || hz);
      @(negedge clk);
      total++; if (decode_stall !== exp_st) begin bad++; $display("FAIL rnd_stall n%0d got=%0b exp=%0b", n, decode_stall, exp_st); end
      total++; if (dec_valid !== m_ex_v) begin bad++; $display("FAIL rnd_valid n%0d got=%0b exp=%0b", n, dec_valid, m_ex_v); end
      if (m_ex_v) begin
        total++;
        if (dec_pc !== 16'(m_ex_pc) || dec_opcode !== 7'(f_op(m_ex_ins)) || dec_rd !== 3'(f_rd(m_ex_ins)) ||
            dec_rs1 !== 3'(f_rs1(m_ex_ins)) || dec_rs2 !== 3'(f_rs2(m_ex_ins)) || dec_imm !== 16'(f_imm(m_ex_ins)) ||
            dec_writes_rd !== f_writes(m_ex_ins) || dec_is_cmp !== (f_op(m_ex_ins) == 5)) begin
          bad++; $display("FAIL rnd_fields n%0d got pc=%h op=%h imm=%h wr=%0b exp pc=%h ins=%h",
                          n, dec_pc, dec_opcode, dec_imm, dec_writes_rd, m_ex_pc, m_ex_ins);
        end
      end
      if (reset) begin
        m_if_v = 0; m_ex_v = 0; m_if_pc = 0; m_if_ins = 0; m_ex_pc = 0; m_ex_ins = 0;
        for (int i = 0; i < 8; i++) m_busy[i] = 0;
      end else begin
        ho = m_ex_v && !execute_stall && !execute_flush;
        if (wb_valid && wb_rd != 3'd0) m_busy[wb_rd] = 0;
        if (ho && f_writes(m_ex_ins)) m_busy[f_rd(m_ex_ins)] = 1;
        if (execute_flush) begin
          m_if_v = 0; m_ex_v = 0;
        end else if (!execute_stall) begin
          if (hz) m_ex_v = 0;
          else begin
            m_ex_v = m_if_v; m_ex_pc = m_if_pc; m_ex_ins = m_if_ins;
            m_if_v = fetch_valid; m_if_pc = int'(fetch_pc); m_if_ins = int'(fetch_instr);
          end
        end
      end
      step();
    end
    reset = 1'b0; idle();
  endtask

  initial begin
    total = 0; bad = 0;
    reset = 1'b1; idle();
    test_reset();
    test_stream();
    test_raw_hazard();
    test_exec_stall();
    test_flush();
    test_imm();
    test_cmp();
    test_set_clear();
    test_r0();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
